// File: rtl/pal_loader_pkg.sv
// ============================================================================
//  Module      : pal_loader_pkg
//  Description : Shared types and constants for the palette loader: state
//                enumeration, palette file geometry and BGR555 packing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pal_loader_pkg;

    // Loader states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } pal_state_t;

    // Palette file geometry: 64 entries of 3 bytes (R, G, B)
    localparam int PAL_BYTES   = 192;
    localparam int PAL_ENTRIES = 64;

    // Pack 5-bit channels into a BGR555 word: R in [4:0], G in [9:5], B in [14:10]
    function automatic logic [14:0] pack_bgr555(
        input logic [4:0] r,
        input logic [4:0] g,
        input logic [4:0] b
    );
        return {b, g, r};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pal_loader.sv
// ============================================================================
//  Module      : pal_loader
//  Description : Receives a palette file over the HPS ioctl download port and
//                turns each R,G,B byte triple into a BGR555 palette RAM write.
//                Bytes beyond the first 192 are address-checked but produce no
//                writes, so extended (emphasis) palette files are accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pal_loader
    import pal_loader_pkg::*;
#(
    parameter logic [7:0] PAL_IDX = 8'd2,
    parameter int         ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        load_color,
    output logic [5:0]  load_color_index,
    output logic [14:0] load_color_data,
    output logic        pal_valid,
    output logic        pal_error,
    output logic        busy
);

    pal_state_t  r_state;
    pal_state_t  w_next;
    logic        r_active_d;
    logic [24:0] r_byte_cnt;
    logic [1:0]  r_phase;
    logic [6:0]  r_entry_cnt;
    logic [4:0]  r_red;
    logic [4:0]  r_green;

    logic        w_active;
    logic        w_start;
    logic        w_wr;
    logic        w_addr_ok;
    logic        w_store;
    logic        w_emit;
    logic        w_enter;
    logic [6:0]  w_entry_next;

    // Only the 5 MSBs of each colour byte reach the palette
    logic        w_unused_bits;
    assign w_unused_bits = &{1'b0, ioctl_dout[2:0]};

    // Download qualification and per-byte decode
    always_comb begin
        w_active     = ioctl_download && (ioctl_index == PAL_IDX);
        w_start      = w_active && !r_active_d;
        // A strobe coincident with the window closing is still taken in RECV
        w_wr         = ioctl_wr && (ioctl_index == PAL_IDX) && (r_state == RECV);
        w_addr_ok    = (ioctl_addr == r_byte_cnt);
        w_store      = w_wr && w_addr_ok && (r_byte_cnt < 25'(PAL_BYTES));
        w_emit       = w_store && (r_phase == 2'd2) && (r_entry_cnt < 7'(PAL_ENTRIES));
        w_entry_next = r_entry_cnt + {6'd0, w_emit};
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the completion check sees the coincident byte's entry
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = RECV;
                end
            end
            RECV: begin
                if (w_wr && !w_addr_ok) begin
                    w_next = ERR;
                end else if (!w_active) begin
                    w_next = (w_entry_next == 7'(ENTRIES)) ? DONE : ERR;
                end
            end
            DONE, ERR: begin
                w_next = w_start ? RECV : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        w_enter = (r_state != RECV) && (w_next == RECV);
    end

    // Byte counting, channel latching, palette write generation and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            // Track the window level so a window still open after reset is not a new start
            r_active_d       <= w_active;
            r_byte_cnt       <= '0;
            r_phase          <= '0;
            r_entry_cnt      <= '0;
            r_red            <= '0;
            r_green          <= '0;
            load_color       <= 1'b0;
            load_color_index <= '0;
            load_color_data  <= '0;
            pal_valid        <= 1'b0;
            pal_error        <= 1'b0;
        end else begin
            r_active_d <= w_active;
            load_color <= 1'b0;
            if (w_enter) begin
                r_byte_cnt  <= '0;
                r_phase     <= '0;
                r_entry_cnt <= '0;
                pal_valid   <= 1'b0;
                pal_error   <= 1'b0;
            end else begin
                if (w_wr && w_addr_ok) begin
                    r_byte_cnt <= r_byte_cnt + 25'd1;
                    r_phase    <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
                end
                if (w_store) begin
                    case (r_phase)
                        2'd0:    r_red   <= ioctl_dout[7:3];
                        2'd1:    r_green <= ioctl_dout[7:3];
                        default: ;
                    endcase
                end
                if (w_emit) begin
                    load_color       <= 1'b1;
                    load_color_index <= r_entry_cnt[5:0];
                    load_color_data  <= pack_bgr555(r_red, r_green, ioctl_dout[7:3]);
                end
                r_entry_cnt <= w_entry_next;
                if ((r_state == RECV) && (w_next == DONE)) begin
                    pal_valid <= 1'b1;
                end
                if ((r_state == RECV) && (w_next == ERR)) begin
                    pal_error <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == RECV);

endmodule

`default_nettype wire

// File: tb/tb_pal_loader.sv
// ============================================================================
//  Module      : tb_pal_loader
//  Description : Directed self-checking bench for pal_loader with a queue-based
//                model of the expected palette writes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pal_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        load_color;
    logic [5:0]  load_color_index;
    logic [14:0] load_color_data;
    logic        pal_valid;
    logic        pal_error;
    logic        busy;

    always #5 clk = ~clk;

    pal_loader #(
        .PAL_IDX (8'd2),
        .ENTRIES (64)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ioctl_download   (ioctl_download),
        .ioctl_index      (ioctl_index),
        .ioctl_wr         (ioctl_wr),
        .ioctl_addr       (ioctl_addr),
        .ioctl_dout       (ioctl_dout),
        .load_color       (load_color),
        .load_color_index (load_color_index),
        .load_color_data  (load_color_data),
        .pal_valid        (pal_valid),
        .pal_error        (pal_error),
        .busy             (busy)
    );

    typedef struct {
        logic [5:0]  idx;
        logic [14:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  file_mem [0:1535];
    int          vectors     = 0;
    int          miscompares = 0;
    int          strobe_cnt  = 0;
    logic [5:0]  first_idx   = '0;
    logic [14:0] first_data  = '0;
    logic [5:0]  last_idx    = '0;
    logic [5:0]  hold_idx    = '0;
    logic [14:0] hold_data   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Build a file image from a seed
    task automatic fill_file(input int seed);
        for (int i = 0; i < 1536; i++) begin
            file_mem[i] = 8'((i * 37 + seed * 101 + 3) % 256);
        end
    endtask

    // Model: each complete R,G,B triple among the first 192 accepted bytes is one write
    task automatic expect_entries(input int n_accepted);
        int n;
        int ent;
        int r;
        int g;
        int b;
        exp_t e;
        n   = (n_accepted > 192) ? 192 : n_accepted;
        ent = n / 3;
        for (int k = 0; k < ent; k++) begin
            r = int'(file_mem[3 * k]);
            g = int'(file_mem[3 * k + 1]);
            b = int'(file_mem[3 * k + 2]);
            e.idx  = 6'(k);
            e.data = 15'((b / 8) * 1024 + (g / 8) * 32 + (r / 8));
            exp_q.push_back(e);
        end
    endtask

    // Per-cycle compare of strobes against the model and of held outputs
    task automatic monitor();
        logic rst_prev;
        exp_t e;
        rst_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                hold_idx  = '0;
                hold_data = '0;
                check("reset_outputs",
                      {7'd0, load_color, load_color_index, load_color_data, pal_valid, pal_error, busy},
                      32'd0);
            end else if (load_color === 1'b1) begin
                check("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("strobe_index", {26'd0, load_color_index}, {26'd0, e.idx});
                    check("strobe_data", {17'd0, load_color_data}, {17'd0, e.data});
                end
                if (strobe_cnt == 0) begin
                    first_idx  = load_color_index;
                    first_data = load_color_data;
                end
                last_idx  = load_color_index;
                hold_idx  = load_color_index;
                hold_data = load_color_data;
                strobe_cnt++;
            end else begin
                check("hold_index", {26'd0, load_color_index}, {26'd0, hold_idx});
                check("hold_data", {17'd0, load_color_data}, {17'd0, hold_data});
            end
            rst_prev = reset;
        end
    endtask

    task automatic pulse_byte(input int addr, input logic [7:0] data);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(addr);
        ioctl_dout = data;
        @(posedge clk); #1;
        ioctl_wr   = 1'b0;
        @(posedge clk); #1;
    endtask

    // Send n bytes; from skip_at on the address runs one ahead; optionally close the window on the last byte
    task automatic send_file(input int n, input int skip_at, input bit coincide_end);
        int addr;
        for (int i = 0; i < n; i++) begin
            addr = (skip_at >= 0 && i >= skip_at) ? i + 1 : i;
            if (coincide_end && i == n - 1) begin
                ioctl_download = 1'b0;
            end
            pulse_byte(addr, file_mem[i]);
        end
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", {31'd0, busy}, 32'd0);

        // 192-byte file, first entry FF,00,80, last byte coincident with window close
        fill_file(1);
        file_mem[0] = 8'hFF;
        file_mem[1] = 8'h00;
        file_mem[2] = 8'h80;
        strobe_cnt  = 0;
        expect_entries(192);
        start_dl(8'd2);
        check("s1_busy_active", {31'd0, busy}, 32'd1);
        send_file(192, -1, 1'b1);
        end_dl();
        check("s1_pending", exp_q.size(), 32'd0);
        check("s1_strobes", strobe_cnt, 32'd64);
        check("s1_first_index", {26'd0, first_idx}, 32'd0);
        check("s1_first_data", {17'd0, first_data}, 32'h401F);
        check("s1_last_index", {26'd0, last_idx}, 32'd63);
        check("s1_valid", {31'd0, pal_valid}, 32'd1);
        check("s1_error", {31'd0, pal_error}, 32'd0);
        check("s1_busy_after", {31'd0, busy}, 32'd0);

        // 1536-byte emphasis file
        fill_file(2);
        strobe_cnt = 0;
        expect_entries(1536);
        start_dl(8'd2);
        check("s2_flags_cleared", {30'd0, pal_valid, pal_error}, 32'd0);
        send_file(1536, -1, 1'b0);
        end_dl();
        check("s2_pending", exp_q.size(), 32'd0);
        check("s2_strobes", strobe_cnt, 32'd64);
        check("s2_valid", {31'd0, pal_valid}, 32'd1);
        check("s2_error", {31'd0, pal_error}, 32'd0);

        // Truncated 150-byte file
        fill_file(3);
        strobe_cnt = 0;
        expect_entries(150);
        start_dl(8'd2);
        send_file(150, -1, 1'b0);
        end_dl();
        check("s3_pending", exp_q.size(), 32'd0);
        check("s3_strobes", strobe_cnt, 32'd50);
        check("s3_last_index", {26'd0, last_idx}, 32'd49);
        check("s3_valid", {31'd0, pal_valid}, 32'd0);
        check("s3_error", {31'd0, pal_error}, 32'd1);

        // Address skip at byte 10
        fill_file(4);
        strobe_cnt = 0;
        expect_entries(10);
        start_dl(8'd2);
        send_file(20, 10, 1'b0);
        check("s4_busy_after_err", {31'd0, busy}, 32'd0);
        end_dl();
        check("s4_pending", exp_q.size(), 32'd0);
        check("s4_strobes", strobe_cnt, 32'd3);
        check("s4_error", {31'd0, pal_error}, 32'd1);
        check("s4_valid", {31'd0, pal_valid}, 32'd0);
        check("s4_busy", {31'd0, busy}, 32'd0);

        // Non-palette download target
        fill_file(5);
        strobe_cnt = 0;
        start_dl(8'd1);
        check("s5_busy", {31'd0, busy}, 32'd0);
        send_file(30, -1, 1'b0);
        end_dl();
        check("s5_strobes", strobe_cnt, 32'd0);
        check("s5_error_held", {31'd0, pal_error}, 32'd1);
        check("s5_valid_held", {31'd0, pal_valid}, 32'd0);

        // Reset mid-download, window left open, then a fresh download
        fill_file(6);
        strobe_cnt = 0;
        expect_entries(30);
        start_dl(8'd2);
        send_file(30, -1, 1'b0);
        check("s6_strobes_before", strobe_cnt, 32'd10);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 30; i < 36; i++) begin
            pulse_byte(i, file_mem[i]);
        end
        check("s6_strobes_after", strobe_cnt, 32'd10);
        check("s6_outputs_zero",
              {7'd0, load_color, load_color_index, load_color_data, pal_valid, pal_error, busy}, 32'd0);
        end_dl();
        check("s6_pending", exp_q.size(), 32'd0);

        fill_file(7);
        strobe_cnt = 0;
        expect_entries(192);
        start_dl(8'd2);
        send_file(192, -1, 1'b0);
        end_dl();
        check("s6b_pending", exp_q.size(), 32'd0);
        check("s6b_strobes", strobe_cnt, 32'd64);
        check("s6b_valid", {31'd0, pal_valid}, 32'd1);
        check("s6b_error", {31'd0, pal_error}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
